// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming 2D convolution engine.
// Optional feature: CONV_SAT_EN (saturating output reduction), used in the top level.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Accumulator wide enough for K*K full-scale unsigned products.
    function automatic int acc_width(input int data_w, input int k);
        return 32'sd2 * data_w + clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_row_mac.sv
// One filter row of multiply-accumulate: K unsigned multipliers, a summing
// tree and the accumulator register. clear loads the row sum, accum adds it.
module conv_row_mac
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int ACC_W  = acc_width(DATA_W, K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accum,
    input  logic [K*DATA_W-1:0]   coef,
    input  logic [K*DATA_W-1:0]   pix,
    output logic [ACC_W-1:0]      acc_next
);

    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    row_sum_s;
    logic [2*DATA_W-1:0] prod_s [K];

    // Unsigned full-width products and their sum for the current filter row.
    always_comb begin
        row_sum_s = '0;
        for (int c = 0; c < K; c++) begin
            prod_s[c] = (2*DATA_W)'(coef[c*DATA_W +: DATA_W]) *
                        (2*DATA_W)'(pix[c*DATA_W +: DATA_W]);
            row_sum_s = row_sum_s + ACC_W'(prod_s[c]);
        end
    end

    // Value the accumulator takes this cycle; the top samples it on the last row.
    always_comb begin
        if (clear) begin
            acc_next = row_sum_s;
        end else begin
            acc_next = acc_r + row_sum_s;
        end
    end

    // Accumulator register, updated only while a row is being processed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= '0;
        end else if (clear || accum) begin
            acc_r <= acc_next;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/conv2d_systolic_engine.sv
// Stream-fed KxK over NxN valid convolution engine: loads filter then image,
// computes each output over K row-MAC cycles and emits results row-major.
// Optional feature: define CONV_SAT_EN for saturating output reduction;
// otherwise outputs are the accumulator truncated modulo 2^DATA_W.
module conv2d_systolic_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_N  = 4,
    parameter int K      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int KK    = K * K;
    localparam int TOT   = KK + IMG_N * IMG_N;
    localparam int M     = IMG_N - K + 1;
    localparam int ACC_W = acc_width(DATA_W, K);
    localparam int CNT_W = clog2(TOT + 1);
    localparam int ROW_W = clog2(K + 1);
    localparam int POS_W = clog2(M + 1);

    if (K < 1 || K > IMG_N) begin : g_bad_k
        $error("conv2d_systolic_engine: K must satisfy 1 <= K <= IMG_N");
    end

    state_t                state_r;
    logic [CNT_W-1:0]      load_cnt_r;
    logic [ROW_W-1:0]      row_r;
    logic [POS_W-1:0]      out_r;
    logic [POS_W-1:0]      out_c;
    logic [TOT*DATA_W-1:0] mem_r;
    logic [K*DATA_W-1:0]   coef_s;
    logic [K*DATA_W-1:0]   pix_s;
    logic [ACC_W-1:0]      acc_next_s;
    logic                  beat_s;
    logic                  mac_clear_s;
    logic                  mac_accum_s;

    // Reduce the wide accumulator to an output word.
    function automatic logic [DATA_W-1:0] reduce_acc(input logic [ACC_W-1:0] a);
`ifdef CONV_SAT_EN
        if (a > ACC_W'({DATA_W{1'b1}})) begin
            return {DATA_W{1'b1}};
        end else begin
            return DATA_W'(a);
        end
`else
        return DATA_W'(a);
`endif
    endfunction

    // Load handshake and MAC row controls.
    always_comb begin
        beat_s      = (state_r == LOAD) && in_valid && in_ready;
        mac_clear_s = (state_r == COMPUTE) && (row_r == '0);
        mac_accum_s = (state_r == COMPUTE) && (row_r != '0);
    end

    // Select filter row j and the matching image window row for output (R,C).
    always_comb begin
        coef_s = '0;
        pix_s  = '0;
        for (int c = 0; c < K; c++) begin
            coef_s[c*DATA_W +: DATA_W] =
                DATA_W'(mem_r >> (DATA_W * (int'(row_r) * K + c)));
            pix_s[c*DATA_W +: DATA_W] =
                DATA_W'(mem_r >> (DATA_W * (KK + (int'(out_r) + int'(row_r)) * IMG_N
                                            + int'(out_c) + c)));
        end
    end

    conv_row_mac #(
        .DATA_W (DATA_W),
        .K      (K),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clear    (mac_clear_s),
        .accum    (mac_accum_s),
        .coef     (coef_s),
        .pix      (pix_s),
        .acc_next (acc_next_s)
    );

    // Filter/image register file: word e lands on load beat e (filter first).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r <= '0;
        end else if (beat_s) begin
            for (int e = 0; e < TOT; e++) begin
                if (load_cnt_r == CNT_W'(e)) begin
                    mem_r[e*DATA_W +: DATA_W] <= in_data;
                end
            end
        end else begin
            mem_r <= mem_r;
        end
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            load_cnt_r <= '0;
            row_r      <= '0;
            out_r      <= '0;
            out_c      <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r    <= LOAD;
                        load_cnt_r <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (beat_s) begin
                        if (load_cnt_r == CNT_W'(TOT - 1)) begin
                            state_r  <= COMPUTE;
                            in_ready <= 1'b0;
                            row_r    <= '0;
                            out_r    <= '0;
                            out_c    <= '0;
                        end else begin
                            load_cnt_r <= load_cnt_r + CNT_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (row_r == ROW_W'(K - 1)) begin
                        state_r   <= EMIT;
                        row_r     <= '0;
                        out_valid <= 1'b1;
                        out_data  <= reduce_acc(acc_next_s);
                    end else begin
                        row_r <= row_r + ROW_W'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_r == POS_W'(M - 1) && out_c == POS_W'(M - 1)) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (out_c == POS_W'(M - 1)) begin
                            state_r <= COMPUTE;
                            out_c   <= '0;
                            out_r   <= out_r + POS_W'(1);
                        end else begin
                            state_r <= COMPUTE;
                            out_c   <= out_c + POS_W'(1);
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_systolic_engine.sv
// Scoreboard bench for conv2d_systolic_engine: directed frames push expected
// outputs; independent monitors pop and compare on every output handshake.
module tb_conv2d_systolic_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [7:0] in_data, out_data;
    logic       start2, in_valid2, in_ready2, out_valid2, out_ready2, busy2, done2;
    logic [7:0] in_data2, out_data2;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         done_cnt     = 0;
    int         done2_cnt    = 0;
    int         done_target  = 0;
    int         beat_cyc     = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    int         rise_q[$];

    logic [7:0] f_vec1[9]  = '{8'd181, 8'd176, 8'd207, 8'd111, 8'd248, 8'd115, 8'd64, 8'd95, 8'd253};
    logic [7:0] f_ident[9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] f_ones[9]  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    logic [7:0] img1[16]   = '{8'd252, 8'd165, 8'd199, 8'd27, 8'd93, 8'd28, 8'd86, 8'd176,
                               8'd149, 8'd110, 8'd113, 8'd249, 8'd234, 8'd207, 8'd29, 8'd30};
    logic [7:0] img_ones[16] = '{default: 8'd1};
`ifdef CONV_SAT_EN
    logic [7:0] exp_vec1[4] = '{8'd255, 8'd255, 8'd255, 8'd255};
`else
    logic [7:0] exp_vec1[4] = '{8'd89, 8'd86, 8'd115, 8'd106};
`endif
    logic [7:0] exp_ident[4] = '{8'd28, 8'd86, 8'd110, 8'd113};

    conv2d_systolic_engine #(.DATA_W(8), .IMG_N(4), .K(3)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    conv2d_systolic_engine #(.DATA_W(8), .IMG_N(5), .K(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_data(out_data2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input int got, input int expv);
        tests_run = tests_run + 1;
        if (got !== expv) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor for the default-size engine.
    initial begin : monitor
        logic       prev_v;
        logic [7:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (out_valid && !prev_v) rise_q.push_back(cyc);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", int'(out_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", int'(out_data), int'(e));
                    end
                end
                if (done) done_cnt = done_cnt + 1;
            end
            prev_v = out_valid;
        end
    end

    // Monitor for the IMG_N=5, K=2 engine.
    initial begin : monitor2
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (out_valid2 && out_ready2) begin
                    if (exp2_q.size() == 0) begin
                        check("unexpected_output2", int'(out_data2), -1);
                    end else begin
                        e = exp2_q.pop_front();
                        check("out_data2", int'(out_data2), int'(e));
                    end
                end
                if (done2) done2_cnt = done2_cnt + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("load_ready_timeout", 0, 1);
        tick();
        beat_cyc = cyc - 1;
        in_valid = 1'b0;
    endtask

    task automatic load_frame(input logic [7:0] f[9], input logic [7:0] im[16], input int gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 9; k++) send(f[k], gap);
        for (int k = 0; k < 16; k++) send(im[k], gap);
    endtask

    task automatic push4(input logic [7:0] v[4]);
        for (int k = 0; k < 4; k++) exp_q.push_back(v[k]);
    endtask

    task automatic wait_done(input string name);
        int n;
        done_target = done_target + 1;
        n = 0;
        while (done_cnt < done_target && n < 300) begin
            tick();
            n++;
        end
        check({name, "_done_count"}, done_cnt, done_target);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin : stimulus
        int n;
        logic [7:0] ones4[4];
        ones4 = '{8'd9, 8'd9, 8'd9, 8'd9};
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        start2 = 1'b0; in_valid2 = 1'b0; in_data2 = 8'd0; out_ready2 = 1'b1;
        tick(); tick();
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b1;
        tick();

        // Reference vector, gapless.
        push4(exp_vec1);
        load_frame(f_vec1, img1, 0);
        check("vec1_busy_compute", int'(busy), 1);
        wait_done("vec1");

        // Identity filter: latency and start ignored on the last handshake.
        push4(exp_ident);
        rise_q.delete();
        load_frame(f_ident, img1, 0);
        n = 0;
        while (!(out_valid && exp_q.size() == 1) && n < 200) begin
            tick();
            n++;
        end
        check("ident_last_seen", int'(out_valid), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ident_done_pulse", int'(done), 1);
        check("ident_busy_fall", int'(busy), 0);
        tick();
        check("ident_done_one_cycle", int'(done), 0);
        check("ident_start_ignored", int'(in_ready), 0);
        done_target = done_target + 1;
        check("ident_done_count", done_cnt, done_target);
        check("ident_queue_empty", exp_q.size(), 0);
        check("ident_latency", (rise_q.size() > 0) ? rise_q[0] - beat_cyc : -1, 4);

        // All-ones: throughput of one output per K+1 cycles.
        push4(ones4);
        rise_q.delete();
        load_frame(f_ones, img_ones, 0);
        wait_done("ones");
        check("ones_rises", rise_q.size(), 4);
        for (int k = 1; k < 4; k++)
            check("ones_spacing", (rise_q.size() > k) ? rise_q[k] - rise_q[k-1] : -1, 4);

        // Back-pressure at the first output.
        out_ready = 1'b0;
        push4(exp_ident);
        load_frame(f_ident, img1, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", int'(out_valid), 1);
            check("hold_data", int'(out_data), 28);
            tick();
        end
        out_ready = 1'b1;
        wait_done("hold");

        // Gapped load must match the gapless result.
        push4(exp_vec1);
        load_frame(f_vec1, img1, 2);
        wait_done("gaps");

        // Reset in the middle of COMPUTE, then a fresh frame.
        load_frame(f_vec1, img1, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        tick();
        rst = 1'b1;
        repeat (8) tick();
        check("rst_no_output", int'(out_valid), 0);
        push4(exp_vec1);
        load_frame(f_vec1, img1, 0);
        wait_done("after_rst");

        // IMG_N=5, K=2, all twos: sixteen outputs of 16.
        for (int k = 0; k < 16; k++) exp2_q.push_back(8'd16);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("k2_in_ready", int'(in_ready2), 1);
        in_valid2 = 1'b1;
        in_data2  = 8'd2;
        repeat (29) tick();
        in_valid2 = 1'b0;
        n = 0;
        while (done2_cnt < 1 && n < 300) begin
            tick();
            n++;
        end
        check("k2_done_count", done2_cnt, 1);
        check("k2_queue_empty", exp2_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/conv2d_systolic_engine.md
# conv2d_systolic_engine

Parametrised, stream-fed successor to the fixed 4x4-input / 3x3-filter / 2x2-output systolic convolvers. It accepts a KxK filter and an NxN image over one valid/ready input stream. It computes all (N-K+1)^2 valid-convolution outputs with a K-wide multiply-accumulate row, and emits them in row-major order over a valid/ready output stream. It sits between the frame loader and the result collector in the convolution datapath.

## Interface
- DATA_W, default 8: width of filter coefficients, pixels and output words.
- IMG_N, default 4: image side length N.
- K, default 3: filter side length. Legal range is 1 <= K <= IMG_N; violations are an elaboration error.
- clk  in  1: single clock; all state is on the rising edge.
- rst  in  1: reset, asynchronous and active-low. rst=0 clears all state immediately, independent of clk.
- start  in  1: one-cycle frame-start request. Honoured only in IDLE.
- in_valid  in  1: in_data is valid.
- in_ready  out  1: engine accepts in_data this cycle.
- in_data  in  DATA_W: filter words first, then pixel words, both row-major, unsigned.
- out_valid  out  1: out_data holds a result.
- out_ready  in  1: downstream accepts out_data.
- out_data  out  DATA_W: convolution result, row-major over the output grid.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse after the last output is accepted.

## Operation
- States are IDLE, LOAD, COMPUTE, EMIT.
- IDLE:
  - start=1 moves to LOAD and clears the load counter.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat stores one word. Beats 0..K*K-1 go to filter f[r][c]; beats K*K..K*K+N*N-1 go to image i[r][c].
  - After the final beat, go to COMPUTE with output index (0,0).
- COMPUTE (output (R,C)), lasting exactly K cycles:
  - Cycle j (0..K-1) adds sum over c of f[j][c]*i[R+j][C+c] to the accumulator.
  - Cycle 0 overwrites the accumulator instead of adding.
  - After cycle K-1, go to EMIT.
- EMIT:
  - out_valid=1, and out_data stays stable until out_valid&out_ready.
  - On the handshake, advance (C first, then R) to the next output and go to COMPUTE.
  - After the last output, pulse done and go to IDLE.
- Arithmetic:
  - Unsigned throughout. Products are 2*DATA_W bits.
  - Accumulator width is ACC_W = 2*DATA_W + clog2(K*K), so it never overflows.
  - Output reduction to DATA_W follows the Configuration section.
- The stored filter and image persist across frames but are always reloaded in LOAD.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0. State is IDLE; counters and accumulator are 0.
- start at cycle t puts the engine in LOAD at t+1, with in_ready=1 from t+1.
- The final load beat at cycle t puts the engine in COMPUTE at t+1. out_valid rises at t+K+1.
- Throughput is one output per K+1 cycles when out_ready is held high.
- Handshake rules:
  - in_valid without in_ready means no transfer.
  - in_data is sampled only on the beat.
  - An upstream that drops in_valid mid-load stalls LOAD indefinitely with no timeout.
- Back-pressure: while out_ready=0 in EMIT, out_valid and out_data are held with no drift.
- The done pulse occurs on the cycle after the last out handshake. busy falls on that same cycle.
- Reset asserted mid-frame (any state) returns the engine to IDLE immediately. No partial output appears after reset release.
- start on the same cycle as the last out handshake is ignored.

## Configuration
- Macro: CONV_SAT_EN.
- Defined: out_data = 2^DATA_W-1 when the accumulator exceeds 2^DATA_W-1, otherwise accumulator[DATA_W-1:0].
- Undefined: out_data = accumulator[DATA_W-1:0]. This is modulo truncation and matches the existing 8-bit convolvers bit-exactly.

## Structure
- Package conv_pkg holds:
  - the state enum (IDLE, LOAD, COMPUTE, EMIT);
  - a clog2 function;
  - the ACC_W derivation as a function of DATA_W and K.
- Sub-module conv_row_mac instantiates K multipliers plus an adder tree and the ACC_W accumulator register, with clear and accumulate enables.
- The top level holds the FSM, load and output counters, and the filter/image register files.

## Test plan
- Default params, the 3x3 filter {181,176,207,111,248,115,64,95,253} with the 4x4 image {252,165,199,27,93,28,86,176,149,110,113,249,234,207,29,30}, out_ready=1:
  - CONV_SAT_EN undefined -> first out_data=89;
  - CONV_SAT_EN defined -> first out_data=255.
- Identity filter (centre 1, rest 0) on the same image -> outputs 28, 86, 110, 113 in order, then a done pulse. out_valid rises 4 cycles after the last load beat.
- All-ones filter and all-ones image -> four outputs of 9. Consecutive out_valid rises are 4 cycles apart.
- Hold out_ready=0 for 5 cycles at the first EMIT -> out_valid=1 with out_data unchanged throughout. The next output follows the release.
- Insert in_valid=0 gaps during LOAD -> results identical to the gapless run. Assert rst=0 mid-COMPUTE -> all outputs 0 immediately; a fresh frame after release gives correct results.
- IMG_N=5, K=2 with all-twos data -> 16 outputs of 16, then done.
